// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the MIPS pipeline sequencer: FSM state encoding and
// the per-cycle stage strobe bundle with its canned values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } strobe_t;

  // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
  localparam strobe_t STB_NORM  = 7'b1101011;
  localparam strobe_t STB_HOLD  = 7'b0000000;
  localparam strobe_t STB_STALL = 7'b0001111;
  localparam strobe_t STB_BR    = 7'b1111111;
  localparam strobe_t STB_JMP   = 7'b1111011;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the sequencer (slave).
// Strobes are level signals valid in the same cycle as the hazard inputs that
// produced them; there is no valid/ready exchange, every cycle is a transfer.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic [4:0]       idex_rt;
  logic             idex_mem_read;
  logic             ex_br_taken;
  logic             id_jump;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, idex_mem_read,
           ex_br_taken, id_jump, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, err, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, idex_mem_read,
           ex_br_taken, id_jump, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, err, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX writing a register the ID
// instruction reads. Register 0 never carries a dependency.
module pipe_ctrl_hazard_detect (
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic [4:0] idex_rt,
  input  logic       idex_mem_read,
  output logic       lu_haz
);
  assign lu_haz = idex_mem_read && (idex_rt != 5'd0) &&
                  ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stage enables and flush strobes for load-use
// stalls, branches, jumps and memory waits, plus timeout and perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int LU_W   = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES + 1) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [LU_W-1:0]   LU_INIT   = LU_W'(LU_STALL_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d, eff_state;
  logic [LU_W-1:0]   lu_q, lu_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  strobe_t           stb;
  logic              lu_haz;
  logic              stall_inc, flush_inc;

  pipe_ctrl_hazard_detect u_hazard (
    .ifid_rs       (bus.ifid_rs),
    .ifid_rt       (bus.ifid_rt),
    .ifid_uses_rt  (bus.ifid_uses_rt),
    .idex_rt       (bus.idex_rt),
    .idex_mem_read (bus.idex_mem_read),
    .lu_haz        (lu_haz)
  );

  always_comb begin
    stb       = STB_NORM;
    state_d   = state_q;
    lu_d      = lu_q;
    wait_d    = wait_q;
    eff_state = state_q;
    if (state_q == ST_ERR) begin
      stb = STB_HOLD;
    end else if (bus.mem_busy) begin
      stb     = STB_HOLD;
      wait_d  = wait_q + 1'b1;
      state_d = (wait_q == WAIT_LAST) ? ST_ERR : ST_MEM_WAIT;
    end else begin
      wait_d = '0;
      // Leaving MEM_WAIT resumes a frozen stall and is arbitrated this same cycle.
      if (state_q == ST_MEM_WAIT) begin
        eff_state = (lu_q != '0) ? ST_LU_STALL : ST_RUN;
      end
      if (bus.ex_br_taken) begin
        stb     = STB_BR;
        lu_d    = '0;
        state_d = ST_RUN;
      end else if (lu_haz || (eff_state == ST_LU_STALL)) begin
        stb = STB_STALL;
        if (eff_state == ST_LU_STALL) begin
          lu_d    = lu_q - 1'b1;
          state_d = (lu_q == LU_W'(1)) ? ST_RUN : ST_LU_STALL;
        end else begin
          lu_d    = LU_INIT;
          state_d = (LU_INIT != '0) ? ST_LU_STALL : ST_RUN;
        end
      end else if (bus.id_jump) begin
        stb     = STB_JMP;
        state_d = ST_RUN;
      end else begin
        state_d = ST_RUN;
      end
    end
    // Reset lets every stage load freely so the pipe fills with reset values.
    if (rst) begin
      stb = STB_NORM;
    end
  end

  assign stall_inc = !stb.pc_en && (state_q != ST_ERR);
  assign flush_inc = stb.ifid_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      lu_q    <= '0;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      wait_q  <= wait_d;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_en      = stb.pc_en;
  assign bus.ifid_en    = stb.ifid_en;
  assign bus.ifid_flush = stb.ifid_flush;
  assign bus.idex_en    = stb.idex_en;
  assign bus.idex_flush = stb.idex_flush;
  assign bus.exmem_en   = stb.exmem_en;
  assign bus.memwb_en   = stb.memwb_en;
  assign bus.err        = (state_q == ST_ERR) && !rst;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: one instance with single-cycle load-use stalls and
// 32-bit counters, one with three-cycle stalls and 4-bit counters.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic [4:0] ex_rt;
    logic       mr;
    logic       br;
    logic       jmp;
    logic       busy;
  } stim_t;

  // Expected strobes: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
  localparam logic [6:0] E_NORM  = 7'b1101011;
  localparam logic [6:0] E_HOLD  = 7'b0000000;
  localparam logic [6:0] E_STALL = 7'b0001111;
  localparam logic [6:0] E_BR    = 7'b1111111;
  localparam logic [6:0] E_JMP   = 7'b1111011;
  localparam logic [1:0] RUN = 2'd0, LU = 2'd1, MW = 2'd2, ER = 2'd3;
  localparam logic [9:0] M_ALL = 10'h3FF, M_RST = 10'h3FC;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, mem_read, br_taken, jump, busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_qa[$];
  logic [9:0] exp_qb[$];
  logic [9:0] exp_v;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) ifa ();
  pipe_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.ifid_rs = rs;        assign ifb.ifid_rs = rs;
  assign ifa.ifid_rt = rt;        assign ifb.ifid_rt = rt;
  assign ifa.ifid_uses_rt = uses_rt;  assign ifb.ifid_uses_rt = uses_rt;
  assign ifa.idex_rt = ex_rt;     assign ifb.idex_rt = ex_rt;
  assign ifa.idex_mem_read = mem_read; assign ifb.idex_mem_read = mem_read;
  assign ifa.ex_br_taken = br_taken;   assign ifb.ex_br_taken = br_taken;
  assign ifa.id_jump = jump;      assign ifb.id_jump = jump;
  assign ifa.mem_busy = busy;     assign ifb.mem_busy = busy;

  pipe_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(64), .CNT_W(32)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  pipe_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  function automatic logic [9:0] obs_a();
    return {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_en, ifa.idex_flush,
            ifa.exmem_en, ifa.memwb_en, ifa.err, ifa.state};
  endfunction

  function automatic logic [9:0] obs_b();
    return {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_en, ifb.idex_flush,
            ifb.exmem_en, ifb.memwb_en, ifb.err, ifb.state};
  endfunction

  function automatic stim_t mk(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                               input logic a_uses, input logic [4:0] a_ex, input logic a_mr,
                               input logic a_br, input logic a_jmp, input logic a_busy);
    stim_t s;
    s.rst = r; s.rs = a_rs; s.rt = a_rt; s.uses = a_uses; s.ex_rt = a_ex;
    s.mr = a_mr; s.br = a_br; s.jmp = a_jmp; s.busy = a_busy;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; rs = s.rs; rt = s.rt; uses_rt = s.uses; ex_rt = s.ex_rt;
    mem_read = s.mr; br_taken = s.br; jump = s.jmp; busy = s.busy;
  endtask

  task automatic do_reset();
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    stim_t st[2];
    logic [9:0] e[2];
    st[0] = mk(1, 1, 0, 0, 1, 1, 1, 1, 1); e[0] = {E_NORM, 1'b0, RUN};
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[1] = {E_NORM, 1'b0, RUN};
    apply(st[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      exp_qa.push_back(e[i]);
      exp_qb.push_back(e[i]);
      @(negedge clk);
      exp_v = exp_qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL reset_a step %0d: got %b want %b", i, obs_a(), exp_v);
      end
      exp_v = exp_qb.pop_front();
      n_checks++;
      if (obs_b() !== exp_v) begin
        n_errors++;
        $display("FAIL reset_b step %0d: got %b want %b", i, obs_b(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifa.stall_cnt !== 32'd0 || ifa.flush_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", ifa.stall_cnt, ifa.flush_cnt);
    end
  endtask

  task automatic test_load_use();
    stim_t st[6];
    logic [9:0] e[6];
    st[0] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0); e[0] = {E_STALL, 1'b0, RUN};
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[1] = {E_NORM,  1'b0, RUN};
    st[2] = mk(0, 2, 1, 1, 1, 1, 0, 0, 0); e[2] = {E_STALL, 1'b0, RUN};
    st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = {E_NORM,  1'b0, RUN};
    st[4] = mk(0, 7, 7, 1, 7, 1, 0, 0, 0); e[4] = {E_STALL, 1'b0, RUN};
    st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = {E_NORM,  1'b0, RUN};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      exp_qa.push_back(e[i]);
      @(negedge clk);
      exp_v = exp_qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL load_use step %0d: got %b want %b", i, obs_a(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifa.stall_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL load_use_stall_cnt: got %0d want 3", ifa.stall_cnt);
    end
  endtask

  task automatic test_no_hazard();
    stim_t st[4];
    logic [9:0] e[4];
    st[0] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0);   e[0] = {E_NORM, 1'b0, RUN};
    st[1] = mk(0, 4, 9, 0, 9, 1, 0, 0, 0);   e[1] = {E_NORM, 1'b0, RUN};
    st[2] = mk(0, 9, 0, 0, 9, 0, 0, 0, 0);   e[2] = {E_NORM, 1'b0, RUN};
    st[3] = mk(0, 3, 12, 1, 13, 1, 0, 0, 0); e[3] = {E_NORM, 1'b0, RUN};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_qa.push_back(e[i]);
      @(negedge clk);
      exp_v = exp_qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL no_hazard step %0d: got %b want %b", i, obs_a(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifa.stall_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL no_hazard_stall_cnt: got %0d want 3", ifa.stall_cnt);
    end
  endtask

  task automatic test_branch();
    stim_t st[4];
    logic [9:0] e[4];
    st[0] = mk(0, 1, 0, 0, 1, 1, 1, 1, 0); e[0] = {E_BR,    1'b0, RUN};
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); e[1] = {E_JMP,   1'b0, RUN};
    st[2] = mk(0, 1, 0, 0, 1, 1, 0, 1, 0); e[2] = {E_STALL, 1'b0, RUN};
    st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = {E_NORM,  1'b0, RUN};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_qa.push_back(e[i]);
      @(negedge clk);
      exp_v = exp_qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL branch step %0d: got %b want %b", i, obs_a(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifa.flush_cnt !== 32'd2 || ifa.stall_cnt !== 32'd4) begin
      n_errors++;
      $display("FAIL branch_cnt: got flush %0d stall %0d want 2 4", ifa.flush_cnt, ifa.stall_cnt);
    end
  endtask

  task automatic test_stall_mem();
    stim_t st[9];
    logic [9:0] e[9];
    st[0] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0); e[0] = {E_STALL, 1'b0, RUN};
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[1] = {E_HOLD,  1'b0, LU};
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[2] = {E_HOLD,  1'b0, MW};
    st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = {E_STALL, 1'b0, MW};
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = {E_STALL, 1'b0, LU};
    st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = {E_NORM,  1'b0, RUN};
    st[6] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0); e[6] = {E_STALL, 1'b0, RUN};
    st[7] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0); e[7] = {E_BR,    1'b0, LU};
    st[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[8] = {E_NORM,  1'b0, RUN};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      exp_qb.push_back(e[i]);
      @(negedge clk);
      exp_v = exp_qb.pop_front();
      n_checks++;
      if (obs_b() !== exp_v) begin
        n_errors++;
        $display("FAIL stall_mem step %0d: got %b want %b", i, obs_b(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifb.stall_cnt !== 4'd6 || ifb.flush_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL stall_mem_cnt: got stall %0d flush %0d want 6 1", ifb.stall_cnt, ifb.flush_cnt);
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 132; i++) begin
      if (i < 63 || (i >= 65 && i < 129)) begin
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        e = {E_HOLD, 1'b0, (i == 0 || i == 65) ? RUN : MW};
      end else if (i == 63) begin
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = {E_NORM, 1'b0, MW};
      end else if (i == 64) begin
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = {E_NORM, 1'b0, RUN};
      end else if (i == 130) begin
        s = mk(0, 1, 0, 0, 1, 1, 1, 1, 0);
        e = {E_HOLD, 1'b1, ER};
      end else begin
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, i == 131);
        e = {E_HOLD, 1'b1, ER};
      end
      apply(s);
      exp_qa.push_back(e);
      @(negedge clk);
      exp_v = exp_qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL timeout cycle %0d: got %b want %b", i, obs_a(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifa.stall_cnt !== 32'd127 || ifa.flush_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL timeout_cnt_a: got stall %0d flush %0d want 127 0", ifa.stall_cnt, ifa.flush_cnt);
    end
    n_checks++;
    if (ifb.stall_cnt !== 4'hF || ifb.err !== 1'b1 || ifb.state !== ER) begin
      n_errors++;
      $display("FAIL timeout_b: got stall %0d err %b state %0d want 15 1 3",
               ifb.stall_cnt, ifb.err, ifb.state);
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[9];
    logic [9:0] ea[9], eb[9], m[9];
    st[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0); ea[0] = {E_NORM,  1'b0, RUN}; eb[0] = ea[0]; m[0] = M_RST;
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); ea[1] = {E_NORM,  1'b0, RUN}; eb[1] = ea[1]; m[1] = M_ALL;
    st[2] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0); ea[2] = {E_STALL, 1'b0, RUN}; eb[2] = ea[2]; m[2] = M_ALL;
    st[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0); ea[3] = {E_NORM,  1'b0, RUN}; eb[3] = ea[3]; m[3] = M_RST;
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); ea[4] = {E_NORM,  1'b0, RUN}; eb[4] = ea[4]; m[4] = M_ALL;
    st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); ea[5] = {E_HOLD,  1'b0, RUN}; eb[5] = ea[5]; m[5] = M_ALL;
    st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); ea[6] = {E_HOLD,  1'b0, MW};  eb[6] = ea[6]; m[6] = M_ALL;
    st[7] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1); ea[7] = {E_NORM,  1'b0, RUN}; eb[7] = ea[7]; m[7] = M_RST;
    st[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); ea[8] = {E_NORM,  1'b0, RUN}; eb[8] = ea[8]; m[8] = M_ALL;
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      exp_qa.push_back(ea[i]);
      exp_qb.push_back(eb[i]);
      @(negedge clk);
      exp_v = exp_qa.pop_front();
      n_checks++;
      if ((obs_a() & m[i]) !== (exp_v & m[i])) begin
        n_errors++;
        $display("FAIL reset_mid_a step %0d: got %b want %b", i, obs_a(), exp_v);
      end
      exp_v = exp_qb.pop_front();
      n_checks++;
      if ((obs_b() & m[i]) !== (exp_v & m[i])) begin
        n_errors++;
        $display("FAIL reset_mid_b step %0d: got %b want %b", i, obs_b(), exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ifa.stall_cnt !== 32'd0 || ifa.flush_cnt !== 32'd0 || ifb.stall_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_mid_cnt: got a %0d/%0d b %0d want 0/0 0",
               ifa.stall_cnt, ifa.flush_cnt, ifb.stall_cnt);
    end
  endtask

  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_stall_mem();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
